// File: rtl/emac_tx_arb_pkg.sv
// Shared types and constants for the EMAC transmit-side frame arbiter.
package emac_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int WORD_W  = 32;
  localparam int MOD_W   = 2;
  localparam int ID_W    = 3;
  localparam int WCNT_W  = 9;
  localparam int CNT_W   = 8;
  localparam int MAX_REQ = 8;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/emac_rr_pick.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module emac_rr_pick
  import emac_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  logic [NUM_REQ-1:0] rot;
  logic [3:0]         sum;

  always_comb begin
    // rot[j] is the request at position (rr_ptr + j) mod NUM_REQ
    rot   = NUM_REQ'({req, req} >> rr_ptr);
    found = 1'b0;
    sum   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + 4'(j);
      end
    end
    if (sum >= 4'(NUM_REQ)) begin
      sum = sum - 4'(NUM_REQ);
    end
    index = sum[ID_W-1:0];
  end

endmodule

// File: rtl/emac_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the ff_tx_* MAC port between NUM_REQ
// sources, with max-length truncation (eop+err) and discard of the frame tail.
module emac_tx_arbiter
  import emac_tx_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_WORDS = 380
) (
  input  logic                      Clk_user,
  input  logic                      Reset,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  input  logic [NUM_REQ*MOD_W-1:0]  req_mod,
  input  logic [NUM_REQ-1:0]        req_sop,
  input  logic [NUM_REQ-1:0]        req_eop,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic [WORD_W-1:0]         ff_tx_data,
  output logic [MOD_W-1:0]          ff_tx_mod,
  output logic                      ff_tx_sop,
  output logic                      ff_tx_eop,
  output logic                      ff_tx_wren,
  output logic                      ff_tx_err,
  input  logic                      ff_tx_rdy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          trunc_cnt,
  output logic [CNT_W-1:0]          stray_cnt
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]    trunc_cnt_q, trunc_cnt_d;
  logic [CNT_W-1:0]    stray_cnt_q, stray_cnt_d;

  logic [WORD_W-1:0]   data_p [MAX_REQ];
  logic [MOD_W-1:0]    mod_p  [MAX_REQ];
  logic [MAX_REQ-1:0]  sop_p, eop_p, valid_p;
  logic [NUM_REQ-1:0]  rdy_int;
  logic [3:0]          n_stray;
  logic [ID_W-1:0]     nxt_ptr;
  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;

  // Pad per-requester lanes to MAX_REQ so grant_id can index them directly
  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_lane
    if (gi < NUM_REQ) begin : g_used
      assign data_p[gi]  = req_data[gi*WORD_W +: WORD_W];
      assign mod_p[gi]   = req_mod[gi*MOD_W +: MOD_W];
      assign sop_p[gi]   = req_sop[gi];
      assign eop_p[gi]   = req_eop[gi];
      assign valid_p[gi] = req_valid[gi];
    end else begin : g_unused
      assign data_p[gi]  = '0;
      assign mod_p[gi]   = '0;
      assign sop_p[gi]   = 1'b0;
      assign eop_p[gi]   = 1'b0;
      assign valid_p[gi] = 1'b0;
    end
  end

  emac_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid & req_sop),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    word_cnt_d  = word_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    stray_cnt_d = stray_cnt_q;
    rdy_int     = '0;
    n_stray     = '0;
    ff_tx_data  = '0;
    ff_tx_mod   = '0;
    ff_tx_sop   = 1'b0;
    ff_tx_eop   = 1'b0;
    ff_tx_wren  = 1'b0;
    ff_tx_err   = 1'b0;
    nxt_ptr     = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    case (state_q)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && !req_sop[i]) begin
            rdy_int[i] = 1'b1;
            n_stray    = n_stray + 4'd1;
          end
        end
        stray_cnt_d = sat_add(stray_cnt_q, n_stray);
        // The sop word stays on the requester; it is transferred from XFER
        if (pick_found) begin
          grant_id_d = pick_idx;
          word_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        ff_tx_data = data_p[grant_id_q];
        ff_tx_mod  = mod_p[grant_id_q];
        ff_tx_sop  = sop_p[grant_id_q];
        ff_tx_eop  = eop_p[grant_id_q];
        ff_tx_wren = valid_p[grant_id_q] & ff_tx_rdy;
        for (int i = 0; i < NUM_REQ; i++) begin
          rdy_int[i] = (ID_W'(i) == grant_id_q) && ff_tx_rdy;
        end
        if (ff_tx_wren) begin
          word_cnt_d = word_cnt_q + WCNT_W'(1);
          if (eop_p[grant_id_q]) begin
            state_d  = IDLE;
            rr_ptr_d = nxt_ptr;
          end else if (word_cnt_q == WCNT_W'(MAX_WORDS - 1)) begin
            ff_tx_eop   = 1'b1;
            ff_tx_err   = 1'b1;
            trunc_cnt_d = sat_add(trunc_cnt_q, 4'd1);
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          rdy_int[i] = (ID_W'(i) == grant_id_q);
        end
        if (valid_p[grant_id_q] && eop_p[grant_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = nxt_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      trunc_cnt_q <= '0;
      stray_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
      stray_cnt_q <= stray_cnt_d;
    end
  end

  // Stray words would otherwise be acknowledged while Reset is held
  assign req_rdy   = Reset ? '0 : rdy_int;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);
  assign trunc_cnt = trunc_cnt_q;
  assign stray_cnt = stray_cnt_q;

endmodule

// File: tb/tb_emac_tx_arbiter.sv
// Directed bench for emac_tx_arbiter: requester queues feed the DUT, a scoreboard
// of expected output words is checked whenever ff_tx_wren fires.
module tb_emac_tx_arbiter;
  localparam int NR = 2;
  localparam int MW = 8;

  logic            Clk_user = 1'b0;
  logic            Reset    = 1'b1;
  logic [NR*32-1:0] req_data;
  logic [NR*2-1:0] req_mod;
  logic [NR-1:0]   req_sop, req_eop, req_valid, req_rdy;
  logic [31:0]     ff_tx_data;
  logic [1:0]      ff_tx_mod;
  logic            ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err, ff_tx_rdy;
  logic [2:0]      grant_id;
  logic            busy;
  logic [7:0]      trunc_cnt, stray_cnt;

  typedef struct packed {logic [31:0] data; logic [1:0] mod; logic sop; logic eop;} word_t;
  typedef struct packed {logic [2:0] id; logic [31:0] data; logic [1:0] mod; logic sop; logic eop; logic err;} exp_t;

  word_t src0[$];
  word_t src1[$];
  exp_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    out_cnt = 0;
  logic [NR-1:0] acc = '0;
  bit    stall_chk = 1'b0;

  emac_tx_arbiter #(.NUM_REQ(NR), .MAX_WORDS(MW)) dut (
    .Clk_user(Clk_user), .Reset(Reset),
    .req_data(req_data), .req_mod(req_mod), .req_sop(req_sop), .req_eop(req_eop),
    .req_valid(req_valid), .req_rdy(req_rdy),
    .ff_tx_data(ff_tx_data), .ff_tx_mod(ff_tx_mod), .ff_tx_sop(ff_tx_sop),
    .ff_tx_eop(ff_tx_eop), .ff_tx_wren(ff_tx_wren), .ff_tx_err(ff_tx_err),
    .ff_tx_rdy(ff_tx_rdy), .grant_id(grant_id), .busy(busy),
    .trunc_cnt(trunc_cnt), .stray_cnt(stray_cnt)
  );

  always #5 Clk_user = ~Clk_user;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    word_t w0, w1;
    w0 = '0;
    w1 = '0;
    if (src0.size() > 0) w0 = src0[0];
    if (src1.size() > 0) w1 = src1[0];
    req_valid = {src1.size() > 0, src0.size() > 0};
    req_data  = {w1.data, w0.data};
    req_mod   = {w1.mod, w0.mod};
    req_sop   = {w1.sop, w0.sop};
    req_eop   = {w1.eop, w0.eop};
  endtask

  task automatic sample();
    exp_t e, o;
    acc = req_valid & req_rdy;
    if (stall_chk) begin
      chk("stall_wren", ff_tx_wren, 0);
      chk("stall_req_rdy", req_rdy, 0);
    end
    if (!busy)
      chk("idle_outputs_zero", {ff_tx_data, ff_tx_mod, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err}, 0);
    if (ff_tx_wren) begin
      o = {grant_id, ff_tx_data, ff_tx_mod, ff_tx_sop, ff_tx_eop, ff_tx_err};
      out_cnt++;
      if (exp_q.size() == 0) chk("unexpected_word_queue_size", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_word", o, e);
      end
    end
  endtask

  task automatic tick();
    word_t dummy;
    @(negedge Clk_user);
    sample();
    @(posedge Clk_user);
    #1;
    if (acc[0]) dummy = src0.pop_front();
    if (acc[1]) dummy = src1.pop_front();
    acc = '0;
    drive();
  endtask

  // Queue a frame on requester r and record what the adapter should see
  task automatic send_frame(input int r, input int n, input logic [31:0] base, input bit with_sop);
    word_t w;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      w.data = base + 32'(k);
      w.sop  = (k == 0) && with_sop;
      w.eop  = (k == n - 1);
      w.mod  = (k == n - 1) ? 2'(n % 4) : 2'd0;
      if (r == 0) src0.push_back(w); else src1.push_back(w);
      if (with_sop && k < MW) begin
        e = {3'(r), w.data, w.mod, w.sop, w.eop, 1'b0};
        if (k == MW - 1 && n > MW) begin
          e.eop = 1'b1;
          e.err = 1'b1;
        end
        exp_q.push_back(e);
      end
    end
    drive();
  endtask

  task automatic wait_done(input string tag, input int budget, output int used);
    used = 0;
    while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0 || busy) && used < budget) begin
      tick();
      used++;
    end
    chk(tag, used < budget, 1);
  endtask

  task automatic wait_out(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (out_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int used;
    int o0;
    ff_tx_rdy = 1'b1;
    drive();
    repeat (3) @(posedge Clk_user);
    #1;
    chk("reset_outputs", {req_rdy, ff_tx_data, ff_tx_mod, ff_tx_sop, ff_tx_eop, ff_tx_wren,
                          ff_tx_err, grant_id, busy, trunc_cnt, stray_cnt}, 0);
    Reset = 1'b0;

    // Simultaneous sop on both requesters: 0 first, one idle cycle, then 1
    send_frame(0, 4, 32'h1000_0000, 1'b1);
    send_frame(1, 4, 32'h2000_0000, 1'b1);
    tick();
    chk("t1_busy_after_arb", busy, 1);
    chk("t1_first_grant", grant_id, 0);
    chk("t1_no_word_in_arb_cycle", out_cnt, 0);
    wait_done("t1_done", 50, used);
    chk("t1_cycles", used + 1, 10);
    chk("t1_last_grant", grant_id, 1);

    // Three 2-word frames each: strict alternation
    for (int f = 0; f < 3; f++) begin
      send_frame(0, 2, 32'h3000_0000 + 32'(f * 16), 1'b1);
      send_frame(1, 2, 32'h4000_0000 + 32'(f * 16), 1'b1);
    end
    wait_done("t2_done", 100, used);
    chk("t2_cycles", used, 18);

    // Backpressure stall mid-frame
    o0 = out_cnt;
    send_frame(0, 6, 32'h5000_0000, 1'b1);
    wait_out("t3_reach_stall", o0 + 2, 20);
    ff_tx_rdy = 1'b0;
    stall_chk = 1'b1;
    repeat (5) tick();
    ff_tx_rdy = 1'b1;
    stall_chk = 1'b0;
    chk("t3_words_during_stall", out_cnt, o0 + 2);
    wait_done("t3_done", 50, used);
    chk("t3_total_words", out_cnt, o0 + 6);

    // 12-word frame against an 8-word limit
    o0 = out_cnt;
    send_frame(1, 12, 32'h6000_0000, 1'b1);
    wait_done("t4_done", 50, used);
    chk("t4_cycles", used, 13);
    chk("t4_words_out", out_cnt, o0 + 8);
    chk("t4_trunc_cnt", trunc_cnt, 1);

    // Stray words in IDLE, then a normal frame
    o0 = out_cnt;
    send_frame(0, 3, 32'h7000_0000, 1'b0);
    send_frame(0, 3, 32'h8000_0000, 1'b1);
    wait_done("t5_done", 50, used);
    chk("t5_stray_cnt", stray_cnt, 3);
    chk("t5_words_out", out_cnt, o0 + 3);
    chk("t5_trunc_kept", trunc_cnt, 1);

    // Reset in the middle of a requester-1 frame
    o0 = out_cnt;
    send_frame(1, 6, 32'h9000_0000, 1'b1);
    wait_out("t6_reach_mid", o0 + 2, 20);
    Reset = 1'b1;
    #1;
    chk("t6_mid_reset_outputs", {req_rdy, ff_tx_data, ff_tx_mod, ff_tx_sop, ff_tx_eop, ff_tx_wren,
                                 ff_tx_err, grant_id, busy, trunc_cnt, stray_cnt}, 0);
    src0.delete();
    src1.delete();
    exp_q.delete();
    acc = '0;
    drive();
    @(posedge Clk_user);
    #1;
    Reset = 1'b0;
    send_frame(0, 2, 32'hB000_0000, 1'b1);
    send_frame(1, 2, 32'hA000_0000, 1'b1);
    tick();
    chk("t6_grant_after_reset", grant_id, 0);
    chk("t6_busy_after_reset", busy, 1);
    wait_done("t6_done", 50, used);
    chk("t6_last_grant", grant_id, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/emac_tx_arbiter.md
# emac_tx_arbiter

Frame-level round-robin arbiter that shares the single user-side MAC transmit port (ff_tx_* word stream into the TX adapter) between NUM_REQ independent frame sources. It grants one requester per frame, passes words through under ff_tx_rdy backpressure, and enforces a maximum frame length. Frames that exceed the limit are truncated with an error marker, and the remainder is discarded. It sits between the requester FIFOs and the TX adapter, in the Clk_user domain.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- MAX_WORDS, 380: maximum 32-bit words per frame (≥2).
- Clk_user  in  1  user clock.
- Reset  in  1  asynchronous, active-high reset.
- req_data  in  NUM_REQ*32  per-requester data; requester i uses bits [32i+31:32i].
- req_mod  in  NUM_REQ*2  per-requester byte-valid code on the eop word; requester i uses [2i+1:2i].
- req_sop, req_eop  in  NUM_REQ  per-requester frame delimiters.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_rdy  out  NUM_REQ  per-requester word accepted this cycle.
- ff_tx_data  out  32, ff_tx_mod  out  2, ff_tx_sop/ff_tx_eop/ff_tx_wren/ff_tx_err  out  1: stream to the TX adapter.
- ff_tx_rdy  in  1  adapter can accept a word.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  state is not IDLE.
- trunc_cnt  out  8  saturating count of truncated frames.
- stray_cnt  out  8  saturating count of words dropped outside a frame.

## Operation
- States are IDLE, XFER and DRAIN. The state, grant_id, rr_ptr, word_cnt and both counters are registered. Everything else is combinational from the registers and inputs.
- **IDLE**
  - Candidates are requesters i with req_valid[i]&req_sop[i].
  - The round-robin picker selects the first candidate at index ≥ rr_ptr, wrapping modulo NUM_REQ.
  - If a candidate exists: grant_id←pick, word_cnt←0, next state XFER. The candidate's sop word is not consumed in IDLE.
  - Any requester with req_valid=1 and req_sop=0 is stray: req_rdy=1 and the word is dropped, stray_cnt+1 per requester per cycle (saturating at 255).
- **XFER**, with g=grant_id
  - Outputs: ff_tx_data/mod/sop/eop = requester g's inputs; req_rdy[g]=ff_tx_rdy; ff_tx_wren=req_valid[g]&ff_tx_rdy; all other req_rdy=0.
  - A word is accepted when ff_tx_wren=1. Each accepted word does word_cnt+1.
  - Accepted word with req_eop[g]=1: next state IDLE, rr_ptr←(g+1) mod NUM_REQ.
  - Accepted word with word_cnt==MAX_WORDS-1 and req_eop[g]=0: force ff_tx_eop=1 and ff_tx_err=1 on that word, trunc_cnt+1, next state DRAIN.
  - ff_tx_err=0 in all other cases. A req_sop asserted mid-frame is passed through unchecked.
- **DRAIN**
  - req_rdy[g]=1 and ff_tx_wren=0; requester g's words are discarded.
  - A discarded word with req_eop[g]=1: next state IDLE, rr_ptr←(g+1) mod NUM_REQ.
- **Reset** (also mid-frame): state=IDLE, rr_ptr=0, grant_id=0, word_cnt=0, trunc_cnt=0, stray_cnt=0. Every output is 0, including ff_tx_data and ff_tx_mod.
- ff_tx_data/mod/sop/eop are 0 whenever state≠XFER.

## Timing
- Arbitration takes one cycle. A sop first visible in IDLE at cycle n is granted at edge n+1, and the earliest ff_tx_wren is in cycle n+1.
- There is at least one idle cycle between consecutive frames (the eop cycle, then one IDLE cycle).
- The data path has zero latency in XFER. The adapter registers it.
- ff_tx_rdy=0 in XFER stalls the stream: req_rdy[g]=0, no state or counter change.
- When the requester is invalid in XFER, ff_tx_wren=0 and the grant is held indefinitely. There is no timeout.
- word_cnt is 9 bits (sized for MAX_WORDS ≤ 511) and never wraps, because truncation happens first.
- A one-word frame (sop&eop on the same word) completes in one XFER cycle.

## Structure
- Package emac_tx_arb_pkg holds:
  - the state encoding (IDLE=2'd0, XFER=2'd1, DRAIN=2'd2);
  - the WORD_W=32 and MOD_W=2 constants;
  - the counter width constants.
- Sub-module emac_rr_pick: combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: found and index.
  - Implemented with a double-width rotate and priority encode.

## Test plan
- Both requesters assert a valid sop frame of 4 words in the same cycle after reset → requester 0's 4 words, then 1 idle cycle, then requester 1's 4 words. grant_id goes 0 then 1.
- Requester 1 sends 3 consecutive 2-word frames while requester 0 sends 3 → frames alternate 0,1,0,1,0,1.
- ff_tx_rdy low for 5 cycles mid-frame → no ff_tx_wren and no req_rdy during the stall. The frame resumes with no lost or duplicated words.
- MAX_WORDS=8 with a 12-word frame → 8 words out, the 8th carrying eop=1 and err=1. The 4 remaining words are absorbed with wren=0. trunc_cnt=1, then back to IDLE.
- Requester 0 presents 3 words with sop=0 while IDLE → all dropped and stray_cnt=3. A subsequent sop frame is forwarded normally.
- Reset asserted in the middle of an XFER → all outputs 0 immediately. After release, a new frame is granted to requester 0 first.
